spi_xfer_scheduler: RTL and testbench

- Round-robin scheduler that shares one SPI master among N_SLV requesters; requester i always targets slave i.
- Grants one requester, drives the slave select and master load/data, waits for the master's transfer-done, then returns the received byte to the granted requester.
- Sits between the requesters and the SPI master + slave-select fabric, and guarantees exactly one select is active during any transfer.

---
 rtl/spi_xfer_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_spi_xfer_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_scheduler.sv
// Round-robin scheduler sharing one SPI master among N_SLV requesters (requester i -> slave i).
// Optional watchdog with rsp_err output: define SPI_XFER_SCHED_TIMEOUT_EN.
module spi_xfer_scheduler #(
  parameter int n        = 8,
  parameter int N_SLV    = 3,
  parameter int LOAD_CYC = 4,
  parameter int TIMEOUT  = 1023
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_SLV-1:0]           req,
  input  logic [N_SLV*n-1:0]         tx_data,
  output logic [N_SLV-1:0]           grant,
  output logic [N_SLV-1:0]           sel,
  output logic                       load,
  output logic [n-1:0]               data_in,
  input  logic                       enOut,
  input  logic [n-1:0]               data_out_master,
  output logic                       rsp_valid,
  output logic [$clog2(N_SLV)-1:0]   rsp_id,
  output logic [n-1:0]               rsp_data,
  output logic                       busy
`ifdef SPI_XFER_SCHED_TIMEOUT_EN
  ,
  output logic                       rsp_err
`endif
);

  localparam int IDW     = $clog2(N_SLV);
  localparam int CNT_MAX = (LOAD_CYC > TIMEOUT) ? LOAD_CYC : TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, LOAD, XFER, RESP} state_t;

  state_t            state_q, state_d;
  logic [N_SLV-1:0]  grant_q, grant_d;
  logic [N_SLV-1:0]  sel_q, sel_d;
  logic              load_q, load_d;
  logic [n-1:0]      data_in_q, data_in_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [n-1:0]      rsp_data_q, rsp_data_d;
  logic              busy_q, busy_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              enOut_q;
  logic              done;
  logic              hi_found;
  logic [IDW-1:0]    hi_idx, lo_idx, pick_idx;
`ifdef SPI_XFER_SCHED_TIMEOUT_EN
  logic              err_q, err_d;
`endif

  assign done = enOut & ~enOut_q;

  // Scanning downward leaves the lowest set index: hi_* restricted to >= rr_ptr, lo_* unrestricted (wrap).
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned k = N_SLV; k > 0; k--) begin
      if (req[k-1]) begin
        lo_idx = IDW'(k - 1);
        if ((k - 1) >= 32'(rr_ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(k - 1);
        end
      end
    end
    pick_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = '0;
    sel_d       = sel_q;
    load_d      = 1'b0;
    data_in_d   = data_in_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
`ifdef SPI_XFER_SCHED_TIMEOUT_EN
    err_d       = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d   = N_SLV'(1) << pick_idx;
          sel_d     = N_SLV'(1) << pick_idx;
          data_in_d = tx_data[pick_idx*n +: n];
          rsp_id_d  = pick_idx;
          rr_ptr_d  = (pick_idx == IDW'(N_SLV - 1)) ? '0 : pick_idx + IDW'(1);
          cnt_d     = '0;
          load_d    = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (cnt_q == CW'(LOAD_CYC - 1)) begin
          cnt_d   = '0;
          state_d = XFER;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          load_d = 1'b1;
        end
      end
      XFER: begin
        if (done) begin
          rsp_data_d  = data_out_master;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
`ifdef SPI_XFER_SCHED_TIMEOUT_EN
          err_d       = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_data_d  = '1;
          rsp_valid_d = 1'b1;
          err_d       = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
`endif
        end
      end
      RESP: begin
        sel_d   = '0;
        state_d = IDLE;
`ifdef SPI_XFER_SCHED_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      sel_q       <= '0;
      load_q      <= 1'b0;
      data_in_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      enOut_q     <= 1'b0;
`ifdef SPI_XFER_SCHED_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      load_q      <= load_d;
      data_in_q   <= data_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      enOut_q     <= enOut;
`ifdef SPI_XFER_SCHED_TIMEOUT_EN
      err_q       <= err_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign load      = load_q;
  assign data_in   = data_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
`ifdef SPI_XFER_SCHED_TIMEOUT_EN
  assign rsp_err   = err_q;
`endif

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// Directed bench for spi_xfer_scheduler (n=8, N_SLV=3, LOAD_CYC=4) with a hand-driven SPI master.
module tb_spi_xfer_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [23:0] tx_data;
  logic [2:0]  grant;
  logic [2:0]  sel;
  logic        load;
  logic [7:0]  data_in;
  logic        enOut;
  logic [7:0]  dom;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        busy;
`ifdef SPI_XFER_SCHED_TIMEOUT_EN
  logic        rsp_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  spi_xfer_scheduler #(.n(8), .N_SLV(3), .LOAD_CYC(4), .TIMEOUT(1023)) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .tx_data         (tx_data),
    .grant           (grant),
    .sel             (sel),
    .load            (load),
    .data_in         (data_in),
    .enOut           (enOut),
    .data_out_master (dom),
    .rsp_valid       (rsp_valid),
    .rsp_id          (rsp_id),
    .rsp_data        (rsp_data),
    .busy            (busy)
`ifdef SPI_XFER_SCHED_TIMEOUT_EN
    ,
    .rsp_err         (rsp_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Starts in IDLE with req already driven; ends in the IDLE cycle after RESP exit.
  task automatic xfer(input logic [2:0] eg, input logic [1:0] eid, input logic [7:0] edin,
                      input logic [7:0] rx, input int lat, input logic drop);
    cyc();
    chk("grant", grant, eg);
    chk("sel_at_grant", sel, eg);
    chk("load_at_grant", load, 1);
    chk("data_in", data_in, edin);
    chk("busy", busy, 1);
    if (drop) req = '0;
    for (int i = 1; i < 4; i++) begin
      cyc();
      chk("load_hold", load, 1);
      chk("grant_pulse", grant, 0);
      chk("sel_load", sel, eg);
    end
    cyc();
    chk("load_end", load, 0);
    chk("sel_xfer", sel, eg);
    dom = rx;
    for (int i = 0; i < lat; i++) begin
      cyc();
      chk("no_rsp_wait", rsp_valid, 0);
    end
    enOut = 1'b1;
    cyc();
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, eid);
    chk("rsp_data", rsp_data, rx);
    chk("sel_resp", sel, eg);
    enOut = 1'b0;
    cyc();
    chk("rsp_pulse", rsp_valid, 0);
    chk("sel_gap", sel, 0);
    chk("busy_gap", busy, 0);
  endtask

  initial begin
    rst = 1'b1; req = '0; tx_data = 24'h22A511; enOut = 1'b0; dom = '0;
    cyc();
    cyc();
    chk("rst_grant", grant, 0);
    chk("rst_sel", sel, 0);
    chk("rst_load", load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    rst = 1'b0;
    cyc();
    chk("idle_busy", busy, 0);

    // single request, requester drops req after grant
    req = 3'b010;
    xfer(3'b010, 2'd1, 8'hA5, 8'h3C, 2, 1'b1);

    // rr_ptr=2: req=011 wraps to slave 0 first, then slave 1
    req = 3'b011;
    xfer(3'b001, 2'd0, 8'h11, 8'h5A, 1, 1'b0);
    xfer(3'b010, 2'd1, 8'hA5, 8'hC3, 0, 1'b1);

    // stale done: enOut already high entering XFER; tx_data changed mid-transfer
    req = 3'b100; enOut = 1'b1;
    cyc();
    chk("stale_grant", grant, 3'b100);
    chk("stale_din", data_in, 8'h22);
    req = '0; tx_data = 24'hFFFFFF;
    for (int i = 1; i < 4; i++) cyc();
    cyc();
    chk("stale_load_end", load, 0);
    chk("stale_din_hold", data_in, 8'h22);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("stale_no_rsp_high", rsp_valid, 0);
    end
    enOut = 1'b0;
    cyc();
    chk("stale_no_rsp_low", rsp_valid, 0);
    dom = 8'h96; enOut = 1'b1;
    cyc();
    chk("stale_rsp_valid", rsp_valid, 1);
    chk("stale_rsp_data", rsp_data, 8'h96);
    chk("stale_rsp_id", rsp_id, 2);
    cyc();
    chk("stale_single_rsp", rsp_valid, 0);
    chk("stale_sel_clear", sel, 0);
    cyc();
    chk("stale_no_second", rsp_valid, 0);
    enOut = 1'b0; tx_data = 24'h22A511;

    // reset asserted mid-XFER while sel=100
    req = 3'b100;
    cyc();
    chk("rstx_grant", grant, 3'b100);
    req = '0;
    for (int i = 1; i < 4; i++) cyc();
    cyc();
    chk("rstx_sel", sel, 3'b100);
    cyc();
    #2;
    rst = 1'b1;
    #1;
    chk("rstx_sel_async", sel, 0);
    chk("rstx_load_async", load, 0);
    chk("rstx_busy_async", busy, 0);
    dom = 8'h77; enOut = 1'b1;
    cyc();
    chk("rstx_no_rsp", rsp_valid, 0);
    rst = 1'b0; enOut = 1'b0;
    cyc();
    chk("rstx_post_rsp", rsp_valid, 0);
    chk("rstx_post_busy", busy, 0);

    // contention: all requesting, order from rr_ptr=0 is 0,1,2,0
    req = 3'b111;
    xfer(3'b001, 2'd0, 8'h11, 8'h01, 1, 1'b0);
    xfer(3'b010, 2'd1, 8'hA5, 8'h02, 2, 1'b0);
    xfer(3'b100, 2'd2, 8'h22, 8'h03, 0, 1'b0);
    xfer(3'b001, 2'd0, 8'h11, 8'h04, 3, 1'b0);
    req = '0;
    cyc();
    chk("final_idle_busy", busy, 0);
    chk("final_idle_sel", sel, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
